// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline stage register with valid/ready flow control, flush and optional 2-entry skid.
// Bubble rule: control outputs and branch_taken read as zero whenever no op is held.
module ex_mem_pipe_reg #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned WB_W       = 2,
    parameter int unsigned M_W        = 3,
    parameter int unsigned SKID       = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WB_W-1:0]       ctlwb_out,
    input  logic [M_W-1:0]        ctlm_out,
    input  logic [DATA_W-1:0]     adder_out,
    input  logic                  aluzero,
    input  logic [DATA_W-1:0]     aluout,
    input  logic [DATA_W-1:0]     readdat2,
    input  logic [REG_ADDR_W-1:0] muxout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WB_W-1:0]       wb_ctlout,
    output logic [M_W-1:0]        m_ctlout,
    output logic [DATA_W-1:0]     add_result,
    output logic                  zero,
    output logic [DATA_W-1:0]     alu_result,
    output logic [DATA_W-1:0]     rdata2out,
    output logic [REG_ADDR_W-1:0] five_bit_muxout,
    output logic                  branch_taken,
    output logic [1:0]            occupancy
);

    localparam int unsigned PW = WB_W + M_W + 3 * DATA_W + 1 + REG_ADDR_W;

    logic [PW-1:0]   in_pkt;
    logic [PW-1:0]   main_q;
    logic            main_v;
    logic            accept;
    logic            consume;
    logic [WB_W-1:0] wb_q;
    logic [M_W-1:0]  m_q;

    assign in_pkt  = {ctlwb_out, ctlm_out, adder_out, aluzero, aluout, readdat2, muxout};
    assign accept  = in_valid & in_ready;
    assign consume = main_v & out_ready;

    assign {wb_q, m_q, add_result, zero, alu_result, rdata2out, five_bit_muxout} = main_q;

    assign out_valid    = main_v;
    assign wb_ctlout    = main_v ? wb_q : '0;
    assign m_ctlout     = main_v ? m_q : '0;
    assign branch_taken = main_v & m_q[M_W-1] & zero;

    if (SKID != 0) begin : g_skid
        // State encoding doubles as the occupancy count.
        typedef enum logic [1:0] {
            StEmpty = 2'd0,
            StMain  = 2'd1,
            StFull  = 2'd2
        } state_e;

        state_e        state_q;
        logic [PW-1:0] skid_q;
        logic          ready_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= StEmpty;
                main_q  <= '0;
                skid_q  <= '0;
                ready_q <= 1'b1;
            end else if (flush) begin
                state_q <= StEmpty;
                ready_q <= 1'b1;
            end else begin
                case (state_q)
                    StEmpty: begin
                        if (accept) begin
                            main_q  <= in_pkt;
                            state_q <= StMain;
                        end
                    end
                    StMain: begin
                        if (accept && consume) begin
                            main_q <= in_pkt;
                        end else if (accept) begin
                            skid_q  <= in_pkt;
                            state_q <= StFull;
                            ready_q <= 1'b0;
                        end else if (consume) begin
                            state_q <= StEmpty;
                        end
                    end
                    StFull: begin
                        if (consume) begin
                            main_q  <= skid_q;
                            state_q <= StMain;
                            ready_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= StEmpty;
                        ready_q <= 1'b1;
                    end
                endcase
            end
        end

        assign main_v    = (state_q != StEmpty);
        assign in_ready  = ready_q;
        assign occupancy = state_q;
    end else begin : g_noskid
        logic valid_q;

        // An op accepted under flush is dropped without touching the held data.
        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                main_q  <= '0;
            end else if (flush) begin
                valid_q <= 1'b0;
            end else if (accept) begin
                valid_q <= 1'b1;
                main_q  <= in_pkt;
            end else if (consume) begin
                valid_q <= 1'b0;
            end
        end

        assign main_v    = valid_q;
        assign in_ready  = ~valid_q | out_ready;
        assign occupancy = {1'b0, valid_q};
    end

endmodule
